// File: rtl/pipe_hazard_ctrl.sv
// Pipeline buffer write/flush/bubble control for load-use, redirect and
// data-memory wait hazards, with a wait timeout and saturating event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              ex_redirect,
  input  logic              exmem_memacc,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_write,
  output logic              idex_flush,
  output logic              exmem_write,
  output logic              memwb_bubble,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lu;
  logic              mem_stall;
  logic              wait_expired;
  logic              freeze;
  logic              stall_inc;
  logic              flush_inc;

  assign lu = idex_memread && (idex_rd != '0) &&
              ((idex_rd == id_rs1) || (idex_rd == id_rs2));
  assign mem_stall    = exmem_memacc && !dmem_ready;
  assign wait_expired = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  // Mealy buffer controls; memory wait outranks redirect, which outranks load-use
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_flush   = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    freeze       = 1'b0;
    flush_inc    = 1'b0;
    stall_inc    = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            freeze = 1'b1;
          end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end
        end
        MEM_WAIT: begin
          // a ready access retires this cycle with normal controls
          freeze = !dmem_ready;
        end
        default: ;
      endcase
    end
    if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
      stall_inc    = 1'b1;
    end
  end

  // State, wait timer, sticky error and saturating counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state <= RUN;
          end else if (wait_expired) begin
            mem_err <= 1'b1;
            state   <= RUN;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected controls are queued as each
// cycle is driven and popped when the outputs are sampled.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW      = 5;
  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 4;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble}
  localparam logic [6:0] C_RUN = 7'b1101010;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_RED = 7'b1111110;
  localparam logic [6:0] C_LU  = 7'b0001110;

  logic              clk;
  logic              reset;
  logic [REG_AW-1:0] id_rs1, id_rs2, idex_rd;
  logic              idex_memread, ex_redirect, exmem_memacc, dmem_ready;
  logic              pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic              exmem_write, memwb_bubble, mem_err;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic [6:0]        ctrl;

  int         checks   = 0;
  int         failures = 0;
  logic [6:0] exp_q[$];

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ex_redirect(ex_redirect), .exmem_memacc(exmem_memacc), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
    .memwb_bubble(memwb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctrl = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                 exmem_write, memwb_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive one cycle of inputs at negedge, queue expected controls, sample before posedge
  task automatic cyc(input string tag, input logic rst,
                     input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                     input logic mr, input logic [REG_AW-1:0] rd,
                     input logic redir, input logic macc, input logic rdy,
                     input logic [6:0] exp);
    logic [6:0] e;
    @(negedge clk);
    reset        = rst;
    id_rs1       = rs1;
    id_rs2       = rs2;
    idex_memread = mr;
    idex_rd      = rd;
    ex_redirect  = redir;
    exmem_memacc = macc;
    dmem_ready   = rdy;
    exp_q.push_back(exp);
    #2;
    e = exp_q.pop_front();
    check(tag, 32'(ctrl), 32'(e));
  endtask

  task automatic state_chk(input string tag, input int stall, input int flush, input logic err);
    @(posedge clk);
    #1;
    check({tag, "_stall"}, 32'(stall_cnt), 32'(stall));
    check({tag, "_flush"}, 32'(flush_cnt), 32'(flush));
    check({tag, "_err"},   32'(mem_err),   32'(err));
  endtask

  initial begin
    reset = 1'b1;
    id_rs1 = '0; id_rs2 = '0; idex_rd = '0;
    idex_memread = 1'b0; ex_redirect = 1'b0; exmem_memacc = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl",  32'(ctrl),      32'(C_RUN));
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_flush", 32'(flush_cnt), 32'd0);
    check("rst_err",   32'(mem_err),   32'd0);

    // load-use on rs1, then on rs2
    cyc("lu_rs1", 0, 5'd5, 5'd0, 1, 5'd5, 0, 0, 1, C_LU);
    state_chk("lu_rs1", 1, 0, 0);
    cyc("lu_rs2", 0, 5'd3, 5'd7, 1, 5'd7, 0, 0, 1, C_LU);
    state_chk("lu_rs2", 2, 0, 0);

    // no hazard: x0 destination, no memread, no register match
    cyc("x0_guard",  0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 1, C_RUN);
    cyc("no_memrd",  0, 5'd5, 5'd0, 0, 5'd5, 0, 0, 1, C_RUN);
    cyc("no_match",  0, 5'd4, 5'd6, 1, 5'd5, 0, 0, 1, C_RUN);
    state_chk("nohaz", 2, 0, 0);

    // redirect squashes a simultaneous load-use
    cyc("redir_lu", 0, 5'd5, 5'd0, 1, 5'd5, 1, 0, 1, C_RED);
    state_chk("redir_lu", 2, 1, 0);

    // memory wait outranks redirect and load-use; release when ready
    cyc("mw_run",  0, 5'd5, 5'd0, 1, 5'd5, 1, 1, 0, C_FRZ);
    cyc("mw_w1",   0, 5'd5, 5'd0, 1, 5'd5, 1, 1, 0, C_FRZ);
    cyc("mw_w2",   0, 5'd5, 5'd0, 1, 5'd5, 1, 1, 0, C_FRZ);
    cyc("mw_rel",  0, 5'd5, 5'd0, 1, 5'd5, 1, 1, 1, C_RUN);
    state_chk("mw", 5, 1, 0);
    cyc("mw_after", 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 1, C_RED);
    state_chk("mw_after", 5, 2, 0);
    cyc("acc_rdy_lu", 0, 5'd9, 5'd0, 1, 5'd9, 0, 1, 1, C_LU);
    state_chk("acc_rdy_lu", 6, 2, 0);

    // timeout after MEM_TIMEOUT frozen cycles; mem_err is sticky
    for (int i = 0; i < int'(MEM_TIMEOUT); i++)
      cyc("to_frz", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, C_FRZ);
    state_chk("to", 10, 2, 1);
    cyc("to_run1", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, C_RUN);
    cyc("to_run2", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, C_RUN);
    state_chk("to_sticky", 10, 2, 1);

    // reset during the second MEM_WAIT cycle
    cyc("rm_run", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, C_FRZ);
    cyc("rm_w1",  0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, C_FRZ);
    cyc("rm_rst", 1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, C_RUN);
    state_chk("rm_rst", 0, 0, 0);
    cyc("rm_after", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, C_RUN);
    state_chk("rm_after", 0, 0, 0);

    // counters saturate at all ones
    for (int i = 0; i < 17; i++)
      cyc("sat_lu", 0, 5'd2, 5'd0, 1, 5'd2, 0, 0, 1, C_LU);
    state_chk("sat_stall", 15, 0, 0);
    for (int i = 0; i < 17; i++)
      cyc("sat_red", 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 1, C_RED);
    state_chk("sat_flush", 15, 15, 0);

    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
